// File: rtl/rf_ctrl_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Defaults for data/address width, arbiter state encoding and wait counter width.
package rf_ctrl_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_NUM_REGS = 1 << RF_ADDR_W;
  localparam int WAIT_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    FREEZE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for in-flight long-latency destinations plus decode hazard lookup.
// Set/clear land at the next edge; the hazard reads only the registered bits (no bypass).
module rf_scoreboard
  import rf_ctrl_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     set_vld,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     clr_vld,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic                     dec_valid,
  input  logic [ADDR_W-1:0]        dec_rs1,
  input  logic [ADDR_W-1:0]        dec_rs2,
  input  logic [ADDR_W-1:0]        dec_rd,
  output logic                     hazard_stall,
  output logic [(1<<ADDR_W)-1:0]   busy_vec
);

  logic [(1<<ADDR_W)-1:0] busy_q;
  logic [(1<<ADDR_W)-1:0] busy_d;
  logic                   any_busy;

  // Clear first, then set, so an issue landing on a register that is being
  // written back in the same cycle stays busy for the new producer.
  always_comb begin
    busy_d = busy_q;
    if (clr_vld) begin
      busy_d[clr_addr] = 1'b0;
    end
    if (set_vld && (set_addr != '0)) begin
      busy_d[set_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    any_busy     = busy_q[dec_rs1] | busy_q[dec_rs2] | busy_q[dec_rd];
    hazard_stall = !reset && dec_valid && any_busy;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between pipe WB (priority) and the LLU, with a
// bounded-starvation freeze; grant is combinational, freeze_req is a registered state decode.
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int MAX_WAIT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pipe_wb_valid,
  input  logic [ADDR_W-1:0]        pipe_wb_addr,
  input  logic [DATA_W-1:0]        pipe_wb_data,
  input  logic                     llu_issue_valid,
  input  logic [ADDR_W-1:0]        llu_issue_rd,
  input  logic                     llu_wb_valid,
  output logic                     llu_wb_ready,
  input  logic [ADDR_W-1:0]        llu_wb_addr,
  input  logic [DATA_W-1:0]        llu_wb_data,
  input  logic                     dec_valid,
  input  logic [ADDR_W-1:0]        dec_rs1,
  input  logic [ADDR_W-1:0]        dec_rs2,
  input  logic [ADDR_W-1:0]        dec_rd,
  output logic                     hazard_stall,
  output logic                     freeze_req,
  output logic                     rf_write,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic [(1<<ADDR_W)-1:0]   busy_vec
);

  localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_C = WAIT_CNT_W'(MAX_WAIT);

  arb_state_t            state_q;
  arb_state_t            state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q;
  logic [WAIT_CNT_W-1:0] wait_cnt_d;
  logic                  pipe_gnt;
  logic                  llu_gnt;

  assign freeze_req = (state_q == FREEZE);

  // During a freeze the pipe holds its WB and replays it, so only the LLU may win.
  always_comb begin
    pipe_gnt = 1'b0;
    llu_gnt  = 1'b0;
    if (!reset) begin
      if (freeze_req) begin
        llu_gnt = llu_wb_valid;
      end else if (pipe_wb_valid) begin
        pipe_gnt = 1'b1;
      end else if (llu_wb_valid) begin
        llu_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    rf_waddr     = pipe_wb_addr;
    rf_wdata     = pipe_wb_data;
    if (llu_gnt) begin
      rf_waddr = llu_wb_addr;
      rf_wdata = llu_wb_data;
    end
    rf_write     = (pipe_gnt || llu_gnt) && (rf_waddr != '0);
    llu_wb_ready = llu_gnt;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (llu_wb_valid && pipe_wb_valid) begin
          state_d    = WAIT;
          wait_cnt_d = WAIT_CNT_W'(1);
        end
      end
      WAIT: begin
        // A dropped LLU request has nothing left to protect from starvation.
        if (llu_gnt || !llu_wb_valid) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q >= MAX_WAIT_C) begin
          state_d    = FREEZE;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
      end
      FREEZE: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .set_vld      (llu_issue_valid),
    .set_addr     (llu_issue_rd),
    .clr_vld      (llu_gnt),
    .clr_addr     (llu_wb_addr),
    .dec_valid    (dec_valid),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_rd       (dec_rd),
    .hazard_stall (hazard_stall),
    .busy_vec     (busy_vec)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Vector-table bench for rf_wb_arbiter with a write-port scoreboard queue.
module tb_rf_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pipe_wb_valid = 1'b0;
  logic [AW-1:0] pipe_wb_addr = '0;
  logic [DW-1:0] pipe_wb_data = '0;
  logic          llu_issue_valid = 1'b0;
  logic [AW-1:0] llu_issue_rd = '0;
  logic          llu_wb_valid = 1'b0;
  logic          llu_wb_ready;
  logic [AW-1:0] llu_wb_addr = '0;
  logic [DW-1:0] llu_wb_data = '0;
  logic          dec_valid = 1'b0;
  logic [AW-1:0] dec_rs1 = '0;
  logic [AW-1:0] dec_rs2 = '0;
  logic [AW-1:0] dec_rd = '0;
  logic          hazard_stall;
  logic          freeze_req;
  logic          rf_write;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [31:0]   busy_vec;

  rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .pipe_wb_valid(pipe_wb_valid), .pipe_wb_addr(pipe_wb_addr), .pipe_wb_data(pipe_wb_data),
    .llu_issue_valid(llu_issue_valid), .llu_issue_rd(llu_issue_rd),
    .llu_wb_valid(llu_wb_valid), .llu_wb_ready(llu_wb_ready),
    .llu_wb_addr(llu_wb_addr), .llu_wb_data(llu_wb_data),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .hazard_stall(hazard_stall), .freeze_req(freeze_req),
    .rf_write(rf_write), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic pv; logic [4:0] pa; logic [31:0] pd;
    logic iv; logic [4:0] ir;
    logic lv; logic [4:0] la; logic [31:0] ld;
    logic dv; logic [4:0] s1; logic [4:0] s2; logic [4:0] d;
    logic ew; logic [4:0] ea; logic [31:0] ed;
    logic er; logic eh; logic ef; logic [31:0] eb;
  } vec_t;

  typedef struct packed { logic [4:0] a; logic [31:0] d; } wr_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  wr_t  wr_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  localparam logic [31:0] B5  = 32'h0000_0020;
  localparam logic [31:0] B7  = 32'h0000_0080;
  localparam logic [31:0] B12 = 32'h0000_1000;

  function automatic vec_t v(
    input logic rst,
    input logic pv, input logic [4:0] pa, input logic [31:0] pd,
    input logic iv, input logic [4:0] ir,
    input logic lv, input logic [4:0] la, input logic [31:0] ld,
    input logic dv, input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
    input logic ew, input logic [4:0] ea, input logic [31:0] ed,
    input logic er, input logic eh, input logic ef, input logic [31:0] eb);
    vec_t r;
    r.rst = rst; r.pv = pv; r.pa = pa; r.pd = pd; r.iv = iv; r.ir = ir;
    r.lv = lv; r.la = la; r.ld = ld; r.dv = dv; r.s1 = s1; r.s2 = s2; r.d = d;
    r.ew = ew; r.ea = ea; r.ed = ed; r.er = er; r.eh = eh; r.ef = ef; r.eb = eb;
    return r;
  endfunction

  // Pipe WB held high while the LLU waits: five refusals, freeze with LLU grant, then release.
  task automatic add_starvation();
    for (int k = 1; k <= 5; k++)
      tbl.push_back(v(0, 1, 5'(10 + k), 32'(32'h1000 + k), 0, 0, 1, 20, 32'hC0FFEE, 0, 0, 0, 0,
                      1, 5'(10 + k), 32'(32'h1000 + k), 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 16, 32'h1006, 0, 0, 1, 20, 32'hC0FFEE, 0, 0, 0, 0,
                    1, 20, 32'hC0FFEE, 1, 0, 1, 0));
    tbl.push_back(v(0, 1, 16, 32'h1006, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    1, 16, 32'h1006, 0, 0, 0, 0));
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic apply(input int idx, input vec_t x);
    vec_t y;
    wr_t  w;
    @(posedge clk); #1;
    reset = x.rst;
    pipe_wb_valid = x.pv; pipe_wb_addr = x.pa; pipe_wb_data = x.pd;
    llu_issue_valid = x.iv; llu_issue_rd = x.ir;
    llu_wb_valid = x.lv; llu_wb_addr = x.la; llu_wb_data = x.ld;
    dec_valid = x.dv; dec_rs1 = x.s1; dec_rs2 = x.s2; dec_rd = x.d;
    exp_q.push_back(x);
    if (x.ew) begin
      w.a = x.ea; w.d = x.ed;
      wr_q.push_back(w);
    end
    @(negedge clk);
    y = exp_q.pop_front();
    chk($sformatf("v%0d_rf_write", idx), 32'(rf_write), 32'(y.ew));
    chk($sformatf("v%0d_ready", idx), 32'(llu_wb_ready), 32'(y.er));
    chk($sformatf("v%0d_hazard", idx), 32'(hazard_stall), 32'(y.eh));
    chk($sformatf("v%0d_freeze", idx), 32'(freeze_req), 32'(y.ef));
    chk($sformatf("v%0d_busy", idx), busy_vec, y.eb);
  endtask

  // Every performed write must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_write === 1'b1) begin
      if (wr_q.size() == 0) begin
        n_total++;
        $display("FAIL wr_unexpected: write addr %0d data 0x%0h, none expected", rf_waddr, rf_wdata);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        chk("wr_addr", 32'(rf_waddr), 32'(w.a));
        chk("wr_data", rf_wdata, w.d);
      end
    end
  end

  logic          prev_pend = 1'b0;
  logic          prev_rst = 1'b1;
  logic [AW-1:0] prev_la = '0;
  logic [DW-1:0] prev_ld = '0;

  always @(posedge clk) begin
    if (!reset) begin
      assert (!(pipe_wb_valid && !freeze_req && busy_vec[pipe_wb_addr]))
        else $error("illegal: pipe WB to busy register %0d", pipe_wb_addr);
      assert (!(llu_issue_valid && llu_issue_rd != 0 && busy_vec[llu_issue_rd] &&
                !(llu_wb_ready && llu_wb_addr == llu_issue_rd)))
        else $error("illegal: LLU issue to busy register %0d", llu_issue_rd);
      assert (!(prev_pend && !prev_rst && llu_wb_valid &&
                (llu_wb_addr != prev_la || llu_wb_data != prev_ld)))
        else $error("illegal: LLU result changed while waiting");
    end
    prev_pend <= llu_wb_valid && !llu_wb_ready;
    prev_rst  <= reset;
    prev_la   <= llu_wb_addr;
    prev_ld   <= llu_wb_data;
  end

  initial begin
    // reset row: grants and hazard forced low even with requests present
    tbl.push_back(v(1, 1, 3, 32'h11, 0, 0, 1, 9, 32'h99, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // issue rd=7, hazard from next cycle, LLU writeback, stall released after
    tbl.push_back(v(0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 1, 0, B7));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 7, 32'hDEADBEEF, 1, 7, 0, 0, 1, 7, 32'hDEADBEEF, 1, 1, 0, B7));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // pipe wins a collision, LLU taken once pipe idles
    tbl.push_back(v(0, 1, 3, 32'h11, 0, 0, 1, 9, 32'h99, 0, 0, 0, 0, 1, 3, 32'h11, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 9, 32'h99, 0, 0, 0, 0, 1, 9, 32'h99, 1, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // set wins over clear on the same register
    tbl.push_back(v(0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 5, 1, 5, 32'h55, 0, 0, 0, 0, 1, 5, 32'h55, 1, 0, 0, B5));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5, 0, 0, 0, 0, 0, 1, 0, B5));
    // LLU result to x0: handshake without a write
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 32'hABCD, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, B5));
    // issue to x0 and x0 operands never stall
    tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, B5));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, B5));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, B5));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5, 0, 0, 0, 0, 1, 0, B5));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 5, 32'h5A, 0, 0, 0, 0, 1, 5, 32'h5A, 1, 0, 0, B5));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_starvation();
    // reset while WAITing with a busy bit: everything discarded
    tbl.push_back(v(0, 0, 0, 0, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 3, 32'h33, 0, 0, 1, 12, 32'hCC, 0, 0, 0, 0, 1, 3, 32'h33, 0, 0, 0, B12));
    tbl.push_back(v(0, 1, 3, 32'h33, 0, 0, 1, 12, 32'hCC, 0, 0, 0, 0, 1, 3, 32'h33, 0, 0, 0, B12));
    tbl.push_back(v(1, 1, 3, 32'h33, 0, 0, 1, 12, 32'hCC, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0, B12));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // wait count must restart from zero after reset
    add_starvation();

    repeat (3) @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

    @(posedge clk); #1;
    pipe_wb_valid = 1'b0; llu_wb_valid = 1'b0; dec_valid = 1'b0; llu_issue_valid = 1'b0;
    @(negedge clk);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
